// File: rtl/serial_frame_receiver.sv
// ============================================================================
// Module   : serial_frame_receiver
// Purpose  : Start/data/parity/stop deserializer with valid pulse, error flags
//            and a wrapping frame counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_frame_receiver #(
   parameter int DATA_WIDTH = 8,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  serial_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  parity_err,
   output logic                  frame_err,
   output logic                  busy,
   output logic [7:0]            frame_count
);

   localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
   localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   state_t                state_q,       state_d;
   logic [CNT_W-1:0]      bit_cnt_q,     bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q,       shift_d;
   logic                  par_bit_q,     par_bit_d;
   logic [DATA_WIDTH-1:0] data_out_q,    data_out_d;
   logic                  data_valid_q,  data_valid_d;
   logic                  parity_err_q,  parity_err_d;
   logic                  frame_err_q,   frame_err_d;
   logic                  busy_q,        busy_d;
   logic [7:0]            frame_count_q, frame_count_d;

   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      par_bit_d     = par_bit_q;
      data_out_d    = data_out_q;
      data_valid_d  = 1'b0;
      parity_err_d  = parity_err_q;
      frame_err_d   = frame_err_q;
      frame_count_d = frame_count_q;

      case (state_q)
         S_IDLE: begin
            if (serial_in) begin
               state_d   = S_DATA;
               bit_cnt_d = '0;
            end
         end
         S_DATA: begin
            // LSB-first: each data bit lands at the position given by bit_cnt
            for (int i = 0; i < DATA_WIDTH; i++) begin
               if (bit_cnt_q == CNT_W'(i)) begin
                  shift_d[i] = serial_in;
               end
            end
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == C_LAST_BIT) begin
               state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            par_bit_d = serial_in;
            state_d   = S_STOP;
         end
         S_STOP: begin
            data_out_d    = shift_q;
            data_valid_d  = 1'b1;
            frame_err_d   = serial_in;
            parity_err_d  = (PARITY_EN != 0) &&
                            ((^shift_q) ^ par_bit_q ^ (PARITY_ODD != 0));
            frame_count_d = frame_count_q + 8'd1;
            state_d       = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         par_bit_q     <= 1'b0;
         data_out_q    <= '0;
         data_valid_q  <= 1'b0;
         parity_err_q  <= 1'b0;
         frame_err_q   <= 1'b0;
         busy_q        <= 1'b0;
         frame_count_q <= 8'd0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         par_bit_q     <= par_bit_d;
         data_out_q    <= data_out_d;
         data_valid_q  <= data_valid_d;
         parity_err_q  <= parity_err_d;
         frame_err_q   <= frame_err_d;
         busy_q        <= busy_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign data_out    = data_out_q;
   assign data_valid  = data_valid_q;
   assign parity_err  = parity_err_q;
   assign frame_err   = frame_err_q;
   assign busy        = busy_q;
   assign frame_count = frame_count_q;

endmodule

`default_nettype wire
